// File: rtl/irq_ctrl_if.sv
// Core/peripheral interrupt handshake bundle for irq_ctrl.
// The controller takes the slave view; the core and peripherals take the master view.
interface irq_ctrl_if #(
   parameter int unsigned NSRC = 8,
   parameter int unsigned VW   = 6
);
   logic [NSRC-1:0] irq_req;
   logic [NSRC-1:0] irq_exec;
   logic            sreg_i;
   logic            instr_boundary;
   logic            take;
   logic [VW-1:0]   vector;
   logic            take_ack;
   logic            sei;
   logic            cli;
   logic            reti;
   logic            in_isr;
   logic [2:0]      depth;

   modport slave (
      input  irq_req,
      input  instr_boundary,
      input  take_ack,
      input  sei,
      input  cli,
      input  reti,
      output irq_exec,
      output sreg_i,
      output take,
      output vector,
      output in_isr,
      output depth
   );

   modport master (
      output irq_req,
      output instr_boundary,
      output take_ack,
      output sei,
      output cli,
      output reti,
      input  irq_exec,
      input  sreg_i,
      input  take,
      input  vector,
      input  in_isr,
      input  depth
   );
endinterface

// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller: arbitrates level requests, vectors the core at an
// instruction boundary, owns SREG.I and tracks ISR nesting depth.
module irq_ctrl #(
   parameter int unsigned NSRC     = 8,
   parameter int unsigned VW       = 6,
   parameter int unsigned MAX_NEST = 3
) (
   input logic       clk,
   input logic       rst,
   irq_ctrl_if.slave bus
);
   localparam int unsigned IW = (NSRC > 1) ? $clog2(NSRC) : 1;

   if (MAX_NEST < 1 || MAX_NEST > 7) begin : g_bad_max_nest
      $error("irq_ctrl: MAX_NEST must be in 1..7");
   end

   typedef enum logic [0:0] {StIdle, StReq} state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   winner_q, winner_d;
   logic            take_q, take_d;
   logic [VW-1:0]   vector_q, vector_d;
   logic [NSRC-1:0] irq_exec_q, irq_exec_d;
   logic            sreg_i_q, sreg_i_d;
   logic [2:0]      depth_q, depth_d;
   logic            in_isr_q, in_isr_d;

   logic [IW-1:0]   arb_idx;
   logic            any_req;
   logic            ack_fire;
   logic            can_take;

   // Lowest set index wins; scanning downwards leaves the lowest one last.
   always_comb begin
      arb_idx = '0;
      for (int i = int'(NSRC) - 1; i >= 0; i--) begin
         if (bus.irq_req[i]) begin
            arb_idx = IW'(i);
         end
      end
   end

   assign any_req  = |bus.irq_req;
   assign ack_fire = (state_q == StReq) && bus.take_ack;
   assign can_take = sreg_i_q && any_req && bus.instr_boundary && (depth_q < 3'(MAX_NEST));

   always_comb begin
      state_d    = state_q;
      winner_d   = winner_q;
      take_d     = take_q;
      vector_d   = vector_q;
      irq_exec_d = '0;

      unique case (state_q)
         StIdle: begin
            if (can_take) begin
               winner_d = arb_idx;
               take_d   = 1'b1;
               vector_d = VW'(arb_idx) + VW'(1);
               state_d  = StReq;
            end
         end
         StReq: begin
            // Ack beats a simultaneous drop of the winning request.
            if (bus.take_ack) begin
               irq_exec_d[winner_q] = 1'b1;
               take_d               = 1'b0;
               vector_d             = '0;
               state_d              = StIdle;
            end else if (!bus.irq_req[winner_q]) begin
               take_d   = 1'b0;
               vector_d = '0;
               state_d  = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      sreg_i_d = sreg_i_q;
      if (ack_fire) begin
         sreg_i_d = 1'b0;
      end else if (bus.cli) begin
         sreg_i_d = 1'b0;
      end else if (bus.reti || bus.sei) begin
         sreg_i_d = 1'b1;
      end
   end

   // Entry and RETI in the same cycle cancel; depth never leaves 0..MAX_NEST.
   always_comb begin
      depth_d = depth_q;
      if (ack_fire && !bus.reti) begin
         if (depth_q < 3'(MAX_NEST)) begin
            depth_d = depth_q + 3'd1;
         end
      end else if (!ack_fire && bus.reti && (depth_q != 3'd0)) begin
         depth_d = depth_q - 3'd1;
      end
      in_isr_d = (depth_d != 3'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         winner_q   <= '0;
         take_q     <= 1'b0;
         vector_q   <= '0;
         irq_exec_q <= '0;
         sreg_i_q   <= 1'b0;
         depth_q    <= 3'd0;
         in_isr_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         winner_q   <= winner_d;
         take_q     <= take_d;
         vector_q   <= vector_d;
         irq_exec_q <= irq_exec_d;
         sreg_i_q   <= sreg_i_d;
         depth_q    <= depth_d;
         in_isr_q   <= in_isr_d;
      end
   end

   assign bus.irq_exec = irq_exec_q;
   assign bus.sreg_i   = sreg_i_q;
   assign bus.take     = take_q;
   assign bus.vector   = vector_q;
   assign bus.depth    = depth_q;
   assign bus.in_isr   = in_isr_q;

   a_exec_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(irq_exec_q));
   a_exec_single : assert property (@(posedge clk) disable iff (rst)
                                    (irq_exec_q != '0) |=> (irq_exec_q == '0));
   a_take_vector : assert property (@(posedge clk) disable iff (rst)
                                    take_q |-> (vector_q != '0));
   a_depth_bound : assert property (@(posedge clk) disable iff (rst)
                                    depth_q <= 3'(MAX_NEST));
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: integer-level model compared every cycle, plus literal
// expectations on the key steps of each scenario.
module tb_irq_ctrl;
   localparam int NSRC     = 8;
   localparam int VW       = 6;
   localparam int MAX_NEST = 3;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   irq_ctrl_if #(.NSRC(NSRC), .VW(VW)) bus ();

   irq_ctrl #(.NSRC(NSRC), .VW(VW), .MAX_NEST(MAX_NEST)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state: plain integers describing what the outputs must be.
   bit m_valid;
   int m_take, m_vec, m_win, m_exec, m_sreg, m_depth;

   always @(posedge clk) begin
      int ack, nsreg, ndepth, w;
      if (rst) begin
         m_valid = 1'b1;
         m_take = 0; m_vec = 0; m_win = 0; m_exec = -1; m_sreg = 0; m_depth = 0;
      end else if (m_valid) begin
         ack    = (m_take != 0 && bus.take_ack) ? 1 : 0;
         nsreg  = ack ? 0 : bus.cli ? 0 : (bus.reti || bus.sei) ? 1 : m_sreg;
         ndepth = m_depth;
         if (ack && !bus.reti) ndepth = (m_depth < MAX_NEST) ? m_depth + 1 : m_depth;
         else if (!ack && bus.reti && m_depth > 0) ndepth = m_depth - 1;
         m_exec = -1;
         if (m_take != 0) begin
            if (ack) begin
               m_exec = m_win; m_take = 0; m_vec = 0;
            end else if (!bus.irq_req[m_win]) begin
               m_take = 0; m_vec = 0;
            end
         end else if (m_sreg != 0 && bus.irq_req != 0 && bus.instr_boundary &&
                      m_depth < MAX_NEST) begin
            w = -1;
            for (int i = 0; i < NSRC; i++) begin
               if (bus.irq_req[i] && w < 0) w = i;
            end
            m_win = w; m_take = 1; m_vec = w + 1;
         end
         m_sreg  = nsreg;
         m_depth = ndepth;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      logic [NSRC-1:0] e_exec;
      if (m_valid) begin
         e_exec = '0;
         if (m_exec >= 0) e_exec[m_exec] = 1'b1;
         chk("mdl_irq_exec", 32'(bus.irq_exec), 32'(e_exec));
         chk("mdl_take",     32'(bus.take),     32'(m_take));
         chk("mdl_vector",   32'(bus.vector),   32'(m_vec));
         chk("mdl_sreg_i",   32'(bus.sreg_i),   32'(m_sreg));
         chk("mdl_depth",    32'(bus.depth),    32'(m_depth));
         chk("mdl_in_isr",   32'(bus.in_isr),   32'(m_depth != 0));
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks = 0; failures = 0;
      rst = 1'b1;
      bus.irq_req = '0; bus.instr_boundary = 1'b0; bus.take_ack = 1'b0;
      bus.sei = 1'b0; bus.cli = 1'b0; bus.reti = 1'b0;
      step(); step();
      chk("rst_take", 32'(bus.take), 0);
      chk("rst_vector", 32'(bus.vector), 0);
      chk("rst_sreg", 32'(bus.sreg_i), 0);
      chk("rst_depth", 32'(bus.depth), 0);
      chk("rst_exec", 32'(bus.irq_exec), 0);
      chk("rst_in_isr", 32'(bus.in_isr), 0);
      rst = 1'b0;

      // 1. Basic take
      bus.sei = 1'b1; step(); bus.sei = 1'b0;
      chk("t1_sei", 32'(bus.sreg_i), 1);
      bus.irq_req = 8'b0000_0100; bus.instr_boundary = 1'b1; step();
      chk("t1_take", 32'(bus.take), 1);
      chk("t1_vector", 32'(bus.vector), 3);
      bus.instr_boundary = 1'b0; bus.take_ack = 1'b1; step();
      bus.take_ack = 1'b0; bus.irq_req = '0;
      chk("t1_exec", 32'(bus.irq_exec), 32'h04);
      chk("t1_sreg_clr", 32'(bus.sreg_i), 0);
      chk("t1_depth", 32'(bus.depth), 1);
      step();
      chk("t1_exec_once", 32'(bus.irq_exec), 0);
      bus.reti = 1'b1; step(); bus.reti = 1'b0;
      chk("t1_reti_sreg", 32'(bus.sreg_i), 1);
      chk("t1_reti_depth", 32'(bus.depth), 0);

      // 2. Priority and hold
      bus.irq_req = 8'b1000_0000; bus.instr_boundary = 1'b1; step();
      chk("t2_vector", 32'(bus.vector), 8);
      bus.instr_boundary = 1'b0; bus.irq_req = 8'b1000_0010; step();
      chk("t2_hold", 32'(bus.vector), 8);
      bus.take_ack = 1'b1; step(); bus.take_ack = 1'b0;
      chk("t2_exec", 32'(bus.irq_exec), 32'h80);
      bus.irq_req = 8'b0000_0010; bus.reti = 1'b1; step(); bus.reti = 1'b0;
      bus.instr_boundary = 1'b1; step();
      chk("t2_next_vector", 32'(bus.vector), 2);
      bus.instr_boundary = 1'b0; bus.take_ack = 1'b1; step(); bus.take_ack = 1'b0;
      chk("t2_exec2", 32'(bus.irq_exec), 32'h02);
      bus.irq_req = '0; bus.reti = 1'b1; step(); bus.reti = 1'b0;

      // 3. Withdrawal
      bus.irq_req = 8'b0010_0000; bus.instr_boundary = 1'b1; step();
      chk("t3_vector", 32'(bus.vector), 6);
      bus.instr_boundary = 1'b0; bus.irq_req = '0; step();
      chk("t3_take", 32'(bus.take), 0);
      chk("t3_vector0", 32'(bus.vector), 0);
      chk("t3_sreg", 32'(bus.sreg_i), 1);
      step();
      chk("t3_no_exec", 32'(bus.irq_exec), 0);

      // 4. Gating
      bus.cli = 1'b1; step(); bus.cli = 1'b0;
      bus.irq_req = 8'hFF; bus.instr_boundary = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("t4_gated", 32'(bus.take), 0);
      end
      bus.instr_boundary = 1'b0; bus.sei = 1'b1; bus.cli = 1'b1; step();
      bus.sei = 1'b0; bus.cli = 1'b0; bus.irq_req = '0;
      chk("t4_sei_cli", 32'(bus.sreg_i), 0);

      // 5. Nesting saturation
      bus.sei = 1'b1; step(); bus.sei = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         bus.irq_req = 8'b0000_0001; bus.instr_boundary = 1'b1; step();
         chk("t5_take", 32'(bus.take), 1);
         bus.instr_boundary = 1'b0; bus.take_ack = 1'b1; step(); bus.take_ack = 1'b0;
         chk("t5_depth", 32'(bus.depth), 32'(k));
         bus.sei = 1'b1; step(); bus.sei = 1'b0;
      end
      bus.instr_boundary = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t5_held_off", 32'(bus.take), 0);
      end
      bus.reti = 1'b1; step(); bus.reti = 1'b0;
      chk("t5_depth2", 32'(bus.depth), 2);
      step();
      chk("t5_take_again", 32'(bus.take), 1);
      bus.instr_boundary = 1'b0; bus.take_ack = 1'b1; step(); bus.take_ack = 1'b0;
      chk("t5_depth3", 32'(bus.depth), 3);
      bus.irq_req = '0;
      for (int i = 0; i < 3; i++) begin
         bus.reti = 1'b1; step();
      end
      bus.reti = 1'b0;
      chk("t5_unwound", 32'(bus.depth), 0);

      // Ack and RETI together: depth unchanged, SREG.I cleared
      bus.irq_req = 8'b0000_1000; bus.instr_boundary = 1'b1; step();
      bus.instr_boundary = 1'b0; bus.take_ack = 1'b1; bus.reti = 1'b1; step();
      bus.take_ack = 1'b0; bus.reti = 1'b0;
      chk("ackreti_exec", 32'(bus.irq_exec), 32'h08);
      chk("ackreti_depth", 32'(bus.depth), 0);
      chk("ackreti_sreg", 32'(bus.sreg_i), 0);

      // RETI at depth 0 still sets SREG.I
      bus.reti = 1'b1; step(); bus.reti = 1'b0;
      chk("reti0_sreg", 32'(bus.sreg_i), 1);
      chk("reti0_depth", 32'(bus.depth), 0);

      // 6. Reset abort
      bus.irq_req = 8'b0000_0100; bus.instr_boundary = 1'b1; step();
      chk("t6_take", 32'(bus.take), 1);
      bus.instr_boundary = 1'b0; bus.take_ack = 1'b1; rst = 1'b1; step();
      rst = 1'b0; bus.take_ack = 1'b0;
      chk("t6_exec", 32'(bus.irq_exec), 0);
      chk("t6_take0", 32'(bus.take), 0);
      chk("t6_depth", 32'(bus.depth), 0);
      chk("t6_sreg", 32'(bus.sreg_i), 0);
      bus.irq_req = '0; step();
      chk("t6_no_late_exec", 32'(bus.irq_exec), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt controller on the core side of the peripheral interrupt handshake.
- Collects the level `interrupt_request` lines from the timer/counter and other peripherals and arbitrates them by fixed priority.
- Presents a vector to the CPU core at an instruction boundary, then returns a one-cycle `interrupt_executed` pulse to the winning source.
- Owns the global interrupt-enable flag (SREG.I), which is fanned out to every peripheral's `status_reg_interrupt_enable`, and tracks ISR nesting depth.

Parameters:
- NSRC, 8, number of interrupt sources; index 0 is the highest priority.
- VW, 6, width of the vector output.
- MAX_NEST, 3, maximum ISR nesting depth (1..7).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- irq_req  in  NSRC  per-source level interrupt request.
- irq_exec  out  NSRC  one-hot, one-cycle "interrupt executed" pulse back to a source.
- sreg_i  out  1  global interrupt enable (SREG.I), driven to all peripherals.
- instr_boundary  in  1  core is at an instruction boundary this cycle.
- take  out  1  request to the core to vector.
- vector  out  VW  vector number of the pending take.
- take_ack  in  1  core accepts the vector this cycle.
- sei  in  1  core executes SEI.
- cli  in  1  core executes CLI.
- reti  in  1  core executes RETI.
- in_isr  out  1  nesting depth is nonzero.
- depth  out  3  current nesting depth.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: `sreg_i`=0, `take`=0, `vector`=0, `irq_exec`=0, `depth`=0, `in_isr`=0, FSM=IDLE.
- All outputs are registered. Decisions use registered `sreg_i`, so an SEI takes effect for arbitration on the cycle after `sreg_i` rises.
- Arbitration: winner = lowest set index of `irq_req`. Vector = winner+1 (vector 0 is reserved for reset), zero-extended to VW.
- FSM states: IDLE, REQ.
- IDLE:
  - Condition to start a take: `sreg_i`=1 and `|irq_req` and `instr_boundary` and `depth` < MAX_NEST.
  - When the condition holds: latch the winner index, set `take`=1 and `vector`=winner+1 on the next edge, go to REQ.
- REQ:
  - `take` and `vector` are held stable; the winner is not re-arbitrated, even if a higher-priority request arrives.
  - On `take_ack`: pulse `irq_exec[winner]`=1 for exactly one cycle (next edge), clear `sreg_i`, `depth`+=1, clear `take`, zero `vector`, go to IDLE.
  - If `irq_req[winner]` drops without `take_ack`: withdraw — `take`=0, `vector`=0, go to IDLE, no `irq_exec`.
  - If `take_ack` and the drop occur in the same cycle: the ack wins.
- `sreg_i` next-state priority, highest first:
  1. `take_ack` in REQ → 0.
  2. `cli` → 0.
  3. `reti` or `sei` → 1.
  4. Otherwise hold.
- `reti` handling:
  - `depth`>0: `depth`-=1.
  - `depth`=0: `depth` unchanged; `sreg_i` is still set.
  - Same cycle as `take_ack`: `depth` is unchanged (+1 and -1 cancel) and `sreg_i`=0.
- Nesting: an SEI inside an ISR allows a new take from IDLE. `depth` saturates at MAX_NEST; at MAX_NEST, pending requests are held off and `take` stays 0.
- `in_isr` = (`depth` != 0), registered together with `depth`.
- `irq_exec` is never asserted for more than one cycle or for more than one bit.
- Reset mid-operation: reset applied in REQ or in the `irq_exec` cycle aborts immediately. The next cycle shows all reset values; no `irq_exec` pulse is issued.

Test Plan:
1. Basic take: after reset, SEI; `irq_req`=8'b0000_0100, `instr_boundary`=1. Expect `take`=1, `vector`=3 one cycle later. `take_ack`=1 → next cycle `irq_exec`=8'b0000_0100 for 1 cycle, `sreg_i`=0, `depth`=1. RETI → `sreg_i`=1, `depth`=0.
2. Priority and hold: `irq_req`=8'b1000_0000 taken (`vector`=8). While in REQ, raise bit 1. Expect `vector` stays 8; after ack, exec bit 7. Following RETI + boundary → `vector`=2.
3. Withdrawal: in REQ with winner 5, drop `irq_req[5]` with no ack. Expect `take`=0 and `vector`=0 next cycle, `irq_exec` stays 0, `sreg_i` stays 1.
4. Gating: `sreg_i`=0, `irq_req`=8'hFF for 10 boundaries → `take` never asserts. SEI and CLI in the same cycle → `sreg_i` stays 0.
5. Nesting saturation (MAX_NEST=3): three acks, each followed by SEI → `depth`=3. A 4th request with `sreg_i`=1 and `instr_boundary` → `take` stays 0. RETI → `depth`=2, then `take` asserts on the next boundary.
6. Reset abort: assert `rst` in the cycle `take_ack` is sampled. Expect no `irq_exec` pulse; `depth`=0, `sreg_i`=0, `take`=0 the next cycle.
